// File: rtl/nn_pkg.sv
// Shared activation definitions: mode encoding, clamp-branch selector and fixed-point unit values.
package nn_pkg;

  typedef enum logic [1:0] {
    ModeHardtanh = 2'd0,
    ModeRelu     = 2'd1,
    ModeStep     = 2'd2,
    ModeSatpass  = 2'd3
  } act_mode_e;

  // Which value S2 drives onto out_y, decided in S1 at full input width.
  typedef enum logic [2:0] {
    SelLin    = 3'd0,
    SelPosOne = 3'd1,
    SelNegOne = 3'd2,
    SelZero   = 3'd3,
    SelMaxPos = 3'd4,
    SelMinNeg = 3'd5
  } act_sel_e;

  function automatic logic [63:0] one_in(int unsigned frac);
    return 64'd1 << (2 * frac);
  endfunction

  function automatic logic [63:0] one_out(int unsigned frac);
    return 64'd1 << frac;
  endfunction

endpackage

// File: rtl/act_clamp.sv
// Combinational range decision for one accumulator value: picks the output branch and
// flags whether a clamp branch was taken.
module act_clamp
  import nn_pkg::*;
#(
  parameter int unsigned IN_W  = 48,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic signed [IN_W-1:0] x_i,
  input  act_mode_e              mode_i,
  output act_sel_e               sel_o,
  output logic                   sat_o
);

  localparam logic signed [IN_W-1:0] OneIn  = IN_W'(one_in(FRAC));
  localparam logic signed [IN_W-1:0] MaxOut = IN_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [IN_W-1:0] MinOut = ~MaxOut;

  logic signed [IN_W-1:0] shifted;
  logic                   neg, above_one, below_one, above_max, below_min;

  // All decisions are taken on the untruncated value.
  assign shifted   = x_i >>> FRAC;
  assign neg       = x_i[IN_W-1];
  assign above_one = x_i > OneIn;
  assign below_one = x_i < -OneIn;
  assign above_max = shifted > MaxOut;
  assign below_min = shifted < MinOut;

  always_comb begin
    sel_o = SelLin;
    sat_o = 1'b0;
    case (mode_i)
      ModeHardtanh: begin
        if (above_one) begin
          sel_o = SelPosOne;
          sat_o = 1'b1;
        end else if (below_one) begin
          sel_o = SelNegOne;
          sat_o = 1'b1;
        end
      end
      ModeRelu: begin
        if (neg) begin
          sel_o = SelZero;
        end else if (above_max) begin
          sel_o = SelMaxPos;
          sat_o = 1'b1;
        end
      end
      ModeStep: sel_o = neg ? SelNegOne : SelPosOne;
      ModeSatpass: begin
        if (above_max) begin
          sel_o = SelMaxPos;
          sat_o = 1'b1;
        end else if (below_min) begin
          sel_o = SelMinNeg;
          sat_o = 1'b1;
        end
      end
      default: sel_o = SelLin;
    endcase
  end

endmodule

// File: rtl/activation_unit.sv
// Two-stage valid/ready activation pipeline (hardtanh, relu, step, saturating pass) with a
// sticky saturation counter.
module activation_unit
  import nn_pkg::*;
#(
  parameter int unsigned IN_W  = 48,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_x,
  input  logic        [1:0]       in_mode,
  input  logic        [TAG_W-1:0] in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_y,
  output logic        [TAG_W-1:0] out_tag,
  input  logic                    sat_clr,
  output logic        [15:0]      sat_count
);

  localparam logic signed [OUT_W-1:0] OneOut = OUT_W'(one_out(FRAC));
  localparam logic signed [OUT_W-1:0] MaxPos = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MinNeg = {1'b1, {(OUT_W - 1){1'b0}}};

  logic                    run_q;
  logic                    s1_valid_q;
  act_sel_e                s1_sel_q, s1_sel_d;
  logic signed [OUT_W-1:0] s1_lin_q;
  logic                    s1_sat_q, s1_sat_d;
  logic        [TAG_W-1:0] s1_tag_q;
  logic                    s2_valid_q;
  logic signed [OUT_W-1:0] s2_y_q, s2_y_d;
  logic        [TAG_W-1:0] s2_tag_q;
  logic                    s2_sat_q;
  logic        [15:0]      sat_cnt_q, sat_cnt_d;
  logic                    s1_adv, s2_adv, in_fire, out_fire;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  // run_q keeps in_ready low during reset and until the first edge after release.
  assign in_ready = run_q & s1_adv;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_valid_q & out_ready;

  act_clamp #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .FRAC (FRAC)
  ) u_clamp (
    .x_i   (in_x),
    .mode_i(act_mode_e'(in_mode)),
    .sel_o (s1_sel_d),
    .sat_o (s1_sat_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= SelLin;
      s1_lin_q   <= '0;
      s1_sat_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_fire;
      if (in_fire) begin
        s1_sel_q <= s1_sel_d;
        s1_lin_q <= in_x[FRAC+OUT_W-1:FRAC];
        s1_sat_q <= s1_sat_d;
        s1_tag_q <= in_tag;
      end
    end
  end

  always_comb begin
    s2_y_d = s1_lin_q;
    case (s1_sel_q)
      SelPosOne: s2_y_d = OneOut;
      SelNegOne: s2_y_d = -OneOut;
      SelZero:   s2_y_d = '0;
      SelMaxPos: s2_y_d = MaxPos;
      SelMinNeg: s2_y_d = MinNeg;
      default:   s2_y_d = s1_lin_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_tag_q   <= '0;
      s2_sat_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_y_q   <= s2_y_d;
        s2_tag_q <= s1_tag_q;
        s2_sat_q <= s1_sat_q;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_fire && s2_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = s2_y_q;
  assign out_tag   = s2_tag_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: doc/activation_unit.md
ACTIVATION_UNIT -- requirements
Module: activation_unit

Interface
REQ-001 SHALL have parameter IN_W, default 48, signed accumulator input width.
REQ-002 SHALL have parameter OUT_W, default 16, signed activation output width.
REQ-003 SHALL have parameter FRAC, default 8; input carries 2*FRAC fraction bits, output carries FRAC fraction bits.
REQ-004 SHALL have parameter TAG_W, default 4, width of the pass-through channel tag.
REQ-005 SHALL have ports: clk input 1 clock; rst_n input 1 asynchronous active-low reset; in_valid input 1; in_ready output 1; in_x input IN_W signed; in_mode input 2; in_tag input TAG_W; out_valid output 1; out_ready input 1; out_y output OUT_W signed; out_tag output TAG_W; sat_clr input 1; sat_count output 16.
REQ-006 SHALL use one clock, clk, with reset rst_n asynchronous and active-low.

Function
REQ-007 SHALL transfer an input when in_valid and in_ready are both high on a rising clk edge, and an output when out_valid and out_ready are both high.
REQ-008 SHALL sample in_mode and in_tag with in_x at acceptance; later changes SHALL NOT affect samples already accepted.
REQ-009 SHALL use a 2-stage pipeline: S1 registers the comparisons and the truncated value; S2 registers out_y and out_tag. Latency from acceptance to out_valid SHALL be 2 cycles.
REQ-010 SHALL advance a stage when it is empty or the next stage advances; S2 advances on out_ready. in_ready SHALL equal (S1 empty) or (S1 advancing), with no combinational path from in_valid to in_ready.
REQ-011 SHALL sustain 1 sample per cycle while out_ready is high, and SHALL never drop, duplicate or reorder samples under backpressure.
REQ-012 SHALL define ONE_IN = 1 << 2*FRAC, ONE_OUT = 1 << FRAC and LIN = in_x[FRAC+OUT_W-1:FRAC].
REQ-013 Mode 0 HARDTANH: output +ONE_OUT if in_x > ONE_IN, -ONE_OUT if in_x < -ONE_IN, else LIN.
REQ-014 Mode 1 RELU: output 0 if in_x < 0; output max positive OUT_W if in_x >> FRAC exceeds it; else LIN.
REQ-015 Mode 2 STEP: output +ONE_OUT if in_x >= 0, else -ONE_OUT.
REQ-016 Mode 3 SATPASS: output in_x >> FRAC (arithmetic shift) saturated to the signed OUT_W range.
REQ-017 SHALL compare all values signed at full IN_W width; truncation to OUT_W SHALL occur only after the range decision.
REQ-018 SHALL flag a sample as saturated when a clamp branch is taken: modes 0, 1 (upper clamp only) and 3. Mode 2 and RELU zeroing SHALL NOT count.
REQ-019 sat_count SHALL increment by 1 per saturated sample at S2 output transfer, and SHALL hold at 0xFFFF without wrapping.
REQ-020 sat_clr SHALL zero sat_count on the next edge, taking priority over a simultaneous increment.

Reset
REQ-021 On rst_n low, SHALL asynchronously clear S1/S2 valids, out_y, out_tag and sat_count to 0; in_ready SHALL read 0 while in reset.
REQ-022 Samples in flight at reset SHALL be discarded; the first acceptance SHALL occur no earlier than the first edge after rst_n rises.

Structure
REQ-023 SHALL place the mode encoding (HARDTANH=0, RELU=1, STEP=2, SATPASS=3) and the ONE_IN/ONE_OUT derivation in shared package nn_pkg.
REQ-024 SHALL contain one sub-module, act_clamp: combinational range decision and saturate flag, instantiated in S1.

Verification
REQ-025 HARDTANH, defaults: in_x = 0x18000 / -0x18000 / 0x8000 / 0x10000 -> out_y = 0x0100 / 0xFF00 / 0x0080 / 0x0100, each 2 cycles after acceptance; sat_count = 2.
REQ-026 RELU and STEP: RELU in_x = -0x8000 -> 0x0000; RELU 0x7FFFFF00 -> 0x7FFF with sat_count +1; STEP in_x = 0 -> 0x0100; STEP -1 -> 0xFF00.
REQ-027 SATPASS: in_x = 0x00FFFF00 -> 0x7FFF; -0x01000000 -> 0x8000; 0x1234500 -> 0x2345 is wrong and SHALL instead read 0x7FFF (0x12345 exceeds range); 0x0012300 -> 0x0123.
REQ-028 Backpressure: out_ready low for 6 cycles with in_valid held high and tags 0..5 -> exactly 2 accepted, then in_ready low; after release, tags arrive in order 0..5 with no gaps.
REQ-029 Reset and counter: assert rst_n low with 2 samples in flight -> out_valid = 0 immediately and no output after release; drive sat_count to 0xFFFF -> holds; sat_clr together with a saturating transfer -> 0.
